output_port_arbiter: RTL and testbench

- Per-output-port scheduler for the 5-port mesh router; one instance per output direction (E, W, S, N, PE), i.e. five per router.
- Shares one output FIFO write port between the four input-direction routing units that target it. Example: the E output is shared by the W, S, N and PE routing units.
- Takes each requester's req/packet pair, picks one winner per cycle by round-robin, registers the packet into the output FIFO, and returns a one-cycle grant so the winning routing unit pops its input FIFO.
- Tracks downstream back-pressure and flags prolonged stalls.

---
 rtl/output_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_output_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// ---------------------------------------------------------------------------
// output_port_arbiter
//
// Per-output-port scheduler for the 5-port mesh router. Four routing units
// compete for one output FIFO write port. One winner per cycle is picked by
// round-robin. Its packet is registered into the FIFO, and it receives a
// one-cycle grant that doubles as the pop strobe for its input FIFO.
// Downstream back-pressure is tracked, and a prolonged stall raises a sticky
// error flag.
//
// Ports:
//   clk         router clock
//   reset       asynchronous, active-high reset
//   req0..req3  requester i has a packet for this output
//   pkt0..pkt3  packet from requester i, valid while its req is high
//   full        downstream FIFO almost-full (at most one free slot)
//   gnt0..gnt3  combinational grant; requester i's packet is taken this cycle
//   out_packet  registered packet to the output FIFO
//   out_wr_en   registered write strobe to the output FIFO
//   busy        high while the FSM is ACTIVE or STALLED
//   stall_err   sticky flag raised after STALL_MAX blocked cycles
//   grant_ptr   current round-robin priority pointer (debug)
// ---------------------------------------------------------------------------
module output_port_arbiter #(
    parameter int DATA_W    = 64,
    parameter int NREQ      = 4,
    parameter int STALL_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              req2,
    input  logic              req3,
    input  logic [DATA_W-1:0] pkt0,
    input  logic [DATA_W-1:0] pkt1,
    input  logic [DATA_W-1:0] pkt2,
    input  logic [DATA_W-1:0] pkt3,
    input  logic              full,
    output logic              gnt0,
    output logic              gnt1,
    output logic              gnt2,
    output logic              gnt3,
    output logic [DATA_W-1:0] out_packet,
    output logic              out_wr_en,
    output logic              busy,
    output logic              stall_err,
    output logic [1:0]        grant_ptr
);

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_ACTIVE   = 2'd1;
    localparam logic [1:0]  ST_STALLED  = 2'd2;
    localparam logic [15:0] STALL_LIMIT = 16'(STALL_MAX);

    logic [NREQ-1:0]   reqVec;
    logic [NREQ-1:0]   gntVec;
    logic              anyReq;
    logic              accept;
    logic              found;
    logic [1:0]        winner;
    logic [1:0]        scanIdx;
    logic [DATA_W-1:0] winPkt;

    logic [1:0]        state_q, state_d;
    logic [1:0]        grantPtr_q, grantPtr_d;
    logic [DATA_W-1:0] outPacket_q, outPacket_d;
    logic              outWrEn_q, outWrEn_d;
    logic [15:0]       stallCnt_q, stallCnt_d;
    logic              stallErr_q, stallErr_d;

    assign reqVec = {req3, req2, req1, req0};
    assign anyReq = |reqVec;

    // Round-robin scan starting at the priority pointer. The 2-bit index
    // wraps naturally, giving the modulo-4 rotation.
    always_comb begin
        winner  = grantPtr_q;
        found   = 1'b0;
        scanIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scanIdx = grantPtr_q + 2'(k);
            if (!found && reqVec[scanIdx]) begin
                winner = scanIdx;
                found  = 1'b1;
            end
        end
    end

    // Grants are suppressed during reset so no requester pops a packet
    // that the async-cleared write strobe would then discard.
    assign accept = found && !full && !reset;
    assign gntVec = accept ? (NREQ'(1) << winner) : '0;

    assign gnt0 = gntVec[0];
    assign gnt1 = gntVec[1];
    assign gnt2 = gntVec[2];
    assign gnt3 = gntVec[3];

    // Packet steering from the winning requester
    always_comb begin
        case (winner)
            2'd0:    winPkt = pkt0;
            2'd1:    winPkt = pkt1;
            2'd2:    winPkt = pkt2;
            default: winPkt = pkt3;
        endcase
    end

    // Output datapath: the packet holds when nothing is accepted, so the
    // FIFO only ever sees it qualified by the write strobe.
    always_comb begin
        outWrEn_d   = accept;
        outPacket_d = accept ? winPkt : outPacket_q;
        grantPtr_d  = accept ? (winner + 2'd1) : grantPtr_q;
    end

    // Activity FSM on the current request/back-pressure inputs
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (anyReq) state_d = full ? ST_STALLED : ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!anyReq)   state_d = ST_IDLE;
                else if (full) state_d = ST_STALLED;
            end
            ST_STALLED: begin
                if (!anyReq)    state_d = ST_IDLE;
                else if (!full) state_d = ST_ACTIVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Staying in STALLED implies full=1 with a pending request, so that is
    // exactly the blocked-cycle condition; any exit clears the count.
    always_comb begin
        stallCnt_d = '0;
        if (state_q == ST_STALLED && state_d == ST_STALLED) begin
            stallCnt_d = (stallCnt_q == STALL_LIMIT) ? stallCnt_q
                                                     : stallCnt_q + 16'd1;
        end
        stallErr_d = stallErr_q || (stallCnt_q == STALL_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grantPtr_q  <= '0;
            outPacket_q <= '0;
            outWrEn_q   <= 1'b0;
            stallCnt_q  <= '0;
            stallErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grantPtr_q  <= grantPtr_d;
            outPacket_q <= outPacket_d;
            outWrEn_q   <= outWrEn_d;
            stallCnt_q  <= stallCnt_d;
            stallErr_q  <= stallErr_d;
        end
    end

    assign out_packet = outPacket_q;
    assign out_wr_en  = outWrEn_q;
    assign busy       = (state_q != ST_IDLE);
    assign stall_err  = stallErr_q;
    assign grant_ptr  = grantPtr_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_output_port_arbiter
//
// Self-checking bench for output_port_arbiter with a short stall limit.
// A reference model predicts grants, pointer, FSM and stall flag; predicted
// FIFO writes go into a scoreboard queue when stimulus is applied and are
// popped and compared after the clock edge that should produce them.
// ---------------------------------------------------------------------------
module tb_output_port_arbiter;

    localparam int DW = 64;
    localparam int SM = 4;

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] pkt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    reqV;
    logic [DW-1:0] pktV [4];
    logic          full;
    logic          gnt0, gnt1, gnt2, gnt3;
    logic [DW-1:0] outPacket;
    logic          outWrEn;
    logic          busy;
    logic          stallErr;
    logic [1:0]    grantPtr;

    exp_t          sbQ [$];
    int            checks = 0;
    int            errors = 0;

    int            mPtr;
    int            mState;
    int            mCnt;
    logic          mErr;
    logic [DW-1:0] mPkt;

    output_port_arbiter #(
        .DATA_W    (DW),
        .NREQ      (4),
        .STALL_MAX (SM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (reqV[0]),
        .req1       (reqV[1]),
        .req2       (reqV[2]),
        .req3       (reqV[3]),
        .pkt0       (pktV[0]),
        .pkt1       (pktV[1]),
        .pkt2       (pktV[2]),
        .pkt3       (pktV[3]),
        .full       (full),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .gnt2       (gnt2),
        .gnt3       (gnt3),
        .out_packet (outPacket),
        .out_wr_en  (outWrEn),
        .busy       (busy),
        .stall_err  (stallErr),
        .grant_ptr  (grantPtr)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any miss
    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPtr   = 0;
        mState = 0;
        mCnt   = 0;
        mErr   = 1'b0;
        mPkt   = '0;
        sbQ.delete();
    endtask

    // Pop the predicted write and compare the registered outputs
    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sbQ.pop_front();
            check("out_wr_en", {63'd0, outWrEn}, {63'd0, e.wr});
            check("out_packet", outPacket, e.pkt);
        end
        check("grant_ptr", {62'd0, grantPtr}, DW'(mPtr));
        check("busy", {63'd0, busy}, {63'd0, (mState != 0)});
        check("stall_err", {63'd0, stallErr}, {63'd0, mErr});
    endtask

    // One cycle: drive now, check grants, predict, then check after the edge
    task automatic evalCycle(input logic [3:0] r, input logic f);
        int   win;
        int   idx;
        logic acc;
        int   nState;
        int   nCnt;
        logic nErr;
        reqV = r;
        full = f;
        #1;
        win = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (mPtr + k) % 4;
            if (win < 0 && r[idx]) win = idx;
        end
        acc = (win >= 0) && !f;
        check("gnt", {60'd0, gnt3, gnt2, gnt1, gnt0},
              acc ? DW'(64'd1 << win) : DW'(0));
        if (r == 4'd0)  nState = 0;
        else if (f)     nState = 2;
        else            nState = 1;
        nCnt = (mState == 2 && nState == 2) ? ((mCnt == SM) ? mCnt : mCnt + 1) : 0;
        nErr = mErr || (mCnt == SM);
        if (acc) mPkt = pktV[win];
        sbQ.push_back('{wr: acc, pkt: mPkt});
        @(posedge clk);
        #1;
        if (acc) mPtr = (win + 1) % 4;
        mState = nState;
        mCnt   = nCnt;
        mErr   = nErr;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic f);
        @(negedge clk);
        evalCycle(r, f);
    endtask

    // Reset with every requester asking: no grant may leak out
    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        reqV  = 4'hF;
        full  = 1'b0;
        #1;
        check("rst_gnt", {60'd0, gnt3, gnt2, gnt1, gnt0}, 64'd0);
        check("rst_wr_en", {63'd0, outWrEn}, 64'd0);
        check("rst_packet", outPacket, 64'd0);
        check("rst_ptr", {62'd0, grantPtr}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_stall_err", {63'd0, stallErr}, 64'd0);
        @(posedge clk);
        #1;
        check("rst_gnt_edge", {60'd0, gnt3, gnt2, gnt1, gnt0}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        reqV  = 4'd0;
        modelReset();
    endtask

    initial begin
        reset = 1'b1;
        reqV  = 4'd0;
        full  = 1'b0;
        for (int i = 0; i < 4; i++) pktV[i] = '0;
        modelReset();
        applyReset();

        // Single requester: same-cycle grant, one-cycle write latency
        pktV[2] = 64'hA5;
        applyStimulus(4'b0100, 1'b0);
        check("single_packet", outPacket, 64'hA5);
        check("single_ptr", {62'd0, grantPtr}, 64'd3);

        // All four requesting: strict rotation 0,1,2,3,0,1,2,3
        applyReset();
        for (int i = 0; i < 4; i++) pktV[i] = DW'(i);
        for (int n = 0; n < 8; n++) begin
            applyStimulus(4'hF, 1'b0);
            check("rr_order", outPacket, DW'(n % 4));
        end

        // Back-pressure on requester 1 until the stall flag trips
        pktV[1] = 64'h1111;
        for (int n = 0; n < SM + 2; n++) applyStimulus(4'b0010, 1'b1);
        check("stall_flag", {63'd0, stallErr}, 64'd1);
        check("stall_no_wr", {63'd0, outWrEn}, 64'd0);
        applyStimulus(4'b0010, 1'b0);
        check("stall_release_pkt", outPacket, 64'h1111);
        check("stall_sticky", {63'd0, stallErr}, 64'd1);

        // Pointer wrap: from 3, requester 3 beats 0, then 0 is served
        pktV[0] = 64'hC0;
        pktV[3] = 64'hD3;
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b1001, 1'b0);
        check("wrap_first", outPacket, 64'hD3);
        check("wrap_ptr", {62'd0, grantPtr}, 64'd0);
        applyStimulus(4'b1001, 1'b0);
        check("wrap_second", outPacket, 64'hC0);

        // Reset landing mid-cycle while a write is pending and gnt0 is up
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        reqV = 4'b0001;
        full = 1'b0;
        #1;
        check("pre_rst_gnt", {60'd0, gnt3, gnt2, gnt1, gnt0}, 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_gnt", {60'd0, gnt3, gnt2, gnt1, gnt0}, 64'd0);
        check("mid_rst_wr_en", {63'd0, outWrEn}, 64'd0);
        check("mid_rst_packet", outPacket, 64'd0);
        check("mid_rst_ptr", {62'd0, grantPtr}, 64'd0);
        @(posedge clk);
        #1;
        check("mid_rst_wr_edge", {63'd0, outWrEn}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        evalCycle(4'b0001, 1'b0);
        check("post_rst_packet", outPacket, 64'hC0);

        // Request withdrawn while blocked: back to idle with a fresh count
        applyStimulus(4'b0010, 1'b1);
        applyStimulus(4'b0010, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        check("withdraw_busy", {63'd0, busy}, 64'd0);
        for (int n = 0; n < SM + 1; n++) applyStimulus(4'b0010, 1'b1);
        check("withdraw_count_cleared", {63'd0, stallErr}, 64'd0);
        applyStimulus(4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
